// File: rtl/car_pkg.sv
// Shared drive-command and sequencer-state encodings for the car control slice.
// Also used by car_control, so the numeric values here are fixed.
package car_pkg;

    typedef enum logic [2:0] {
        CMD_ZERO    = 3'd0,
        CMD_ACC     = 3'd1,
        CMD_DEC     = 3'd2,
        CMD_LEFT    = 3'd3,
        CMD_RIGHT   = 3'd4,
        CMD_FORWARD = 3'd5,
        CMD_BACK    = 3'd6,
        CMD_STOP    = 3'd7
    } cmd_e;

    typedef enum logic [2:0] {
        ST_MANUAL  = 3'd0,
        ST_HALT    = 3'd1,
        ST_BACKUP  = 3'd2,
        ST_TURN    = 3'd3,
        ST_CHECK   = 3'd4,
        ST_LOCKOUT = 3'd5
    } seq_state_e;

    // Commands that move the car toward whatever is in front of it.
    function automatic logic is_advancing(input logic [2:0] c);
        return (c == CMD_ACC) || (c == CMD_DEC) || (c == CMD_FORWARD);
    endfunction

endpackage

// File: rtl/motion_sequencer_if.sv
// Operator/sensor inputs and drive-command outputs of the motion sequencer.
// The sequencer is the slave; whoever supplies operator and sensor data is the master.
interface motion_sequencer_if;

    logic        auto_en;
    logic [2:0]  man_cmd;
    logic [19:0] cm;
    logic        cm_valid;
    logic [2:0]  cmd;
    logic        override;
    logic        fault;
    logic [2:0]  seq_state;

    modport master (
        output auto_en, man_cmd, cm, cm_valid,
        input  cmd, override, fault, seq_state
    );

    modport slave (
        input  auto_en, man_cmd, cm, cm_valid,
        output cmd, override, fault, seq_state
    );

endinterface

// File: rtl/seq_timer.sv
// Dwell down-counter: load sets the count, then it decrements to 0 and holds there.
// zero is high on every cycle the count sits at 0.
module seq_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        zero
);

    logic [31:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 32'd1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/motion_sequencer.sv
// Obstacle-avoidance sequencer: passes operator commands through, and on a close
// obstacle runs halt -> back up -> turn right -> re-check, locking out after MAX_RETRY tries.
module motion_sequencer
    import car_pkg::*;
#(
    parameter int unsigned HALT_TICKS  = 25_000_000,
    parameter int unsigned BACK_TICKS  = 50_000_000,
    parameter int unsigned TURN_TICKS  = 50_000_000,
    parameter int unsigned STOP_CM     = 25,
    parameter int unsigned CLEAR_CM    = 40,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned STALE_TICKS = 10_000_000
) (
    input  logic               clk,
    input  logic               rst,
    motion_sequencer_if.slave  bus
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    seq_state_e         state_q, state_d;
    logic [RETRY_W-1:0] retry_q;
    logic               retry_clr, retry_inc;
    logic [2:0]         cmd_q, cmd_d;
    logic               override_q, override_d;
    logic [31:0]        stale_q;
    logic               fault;
    logic               timer_load, timer_zero;
    logic [31:0]        timer_val;
    logic               near, clear, advancing;

    assign near      = (bus.cm <= 20'(STOP_CM));
    assign clear     = (bus.cm >  20'(CLEAR_CM));
    assign advancing = is_advancing(bus.man_cmd);
    assign fault     = bus.auto_en && (stale_q == STALE_TICKS);

    seq_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        retry_clr  = 1'b0;
        retry_inc  = 1'b0;
        cmd_d      = CMD_STOP;
        override_d = 1'b1;

        if (!bus.auto_en) begin
            state_d = ST_MANUAL;
        end else begin
            case (state_q)
                ST_MANUAL: begin
                    if (bus.cm_valid && near && advancing) begin
                        state_d   = ST_HALT;
                        retry_clr = 1'b1;
                    end
                end
                ST_HALT:   if (timer_zero) state_d = ST_BACKUP;
                ST_BACKUP: if (timer_zero) state_d = ST_TURN;
                ST_TURN: begin
                    if (timer_zero) begin
                        state_d   = ST_CHECK;
                        retry_inc = 1'b1;
                    end
                end
                ST_CHECK: begin
                    // Stale distance data cannot prove the path clear, so give up at once.
                    if (fault)
                        state_d = ST_LOCKOUT;
                    else if (bus.cm_valid) begin
                        if (clear)
                            state_d = ST_MANUAL;
                        else if (retry_q < RETRY_W'(MAX_RETRY))
                            state_d = ST_BACKUP;
                        else
                            state_d = ST_LOCKOUT;
                    end
                end
                ST_LOCKOUT: if (bus.man_cmd == CMD_STOP) state_d = ST_MANUAL;
                default:    state_d = ST_MANUAL;
            endcase
        end

        case (state_q)
            ST_MANUAL: begin
                if (fault && advancing) begin
                    cmd_d      = CMD_STOP;
                    override_d = 1'b1;
                end else begin
                    cmd_d      = bus.man_cmd;
                    override_d = 1'b0;
                end
            end
            ST_BACKUP: cmd_d = CMD_BACK;
            ST_TURN:   cmd_d = CMD_RIGHT;
            default:   cmd_d = CMD_STOP;
        endcase
    end

    // The dwell timer is armed on the same edge that enters a timed state.
    always_comb begin
        timer_load = (state_d != state_q);
        case (state_d)
            ST_HALT:   timer_val = 32'(HALT_TICKS - 1);
            ST_BACKUP: timer_val = 32'(BACK_TICKS - 1);
            ST_TURN:   timer_val = 32'(TURN_TICKS - 1);
            default:   timer_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_MANUAL;
            retry_q    <= '0;
            cmd_q      <= CMD_ZERO;
            override_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            override_q <= override_d;
            if (retry_clr)
                retry_q <= '0;
            else if (retry_inc)
                retry_q <= retry_q + RETRY_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stale_q <= '0;
        else if (bus.cm_valid)
            stale_q <= '0;
        else if (stale_q != STALE_TICKS)
            stale_q <= stale_q + 32'd1;
    end

    assign bus.cmd       = cmd_q;
    assign bus.override  = override_q;
    assign bus.fault     = fault;
    assign bus.seq_state = state_q;

endmodule

// File: doc/motion_sequencer.md
MOTION_SEQUENCER -- requirements
Module: motion_sequencer

Interface
REQ-001 SHALL have parameter HALT_TICKS, default 25_000_000, meaning the stop dwell in clk cycles before reversing.
REQ-002 SHALL have parameter BACK_TICKS, default 50_000_000, meaning the reverse duration in clk cycles.
REQ-003 SHALL have parameter TURN_TICKS, default 50_000_000, meaning the right-turn duration in clk cycles.
REQ-004 SHALL have parameter STOP_CM, default 25, meaning the obstacle threshold in cm (inclusive).
REQ-005 SHALL have parameter CLEAR_CM, default 40, meaning the path-clear threshold in cm (exclusive); CLEAR_CM > STOP_CM.
REQ-006 SHALL have parameter MAX_RETRY, default 3, meaning the number of back/turn attempts before lockout.
REQ-007 SHALL have parameter STALE_TICKS, default 10_000_000, meaning the longest allowed gap between distance samples.
REQ-008 SHALL have port clk, input, 1 bit, system clock.
REQ-009 SHALL have port rst, input, 1 bit, reset (asynchronous, active-high).
REQ-010 SHALL have port auto_en, input, 1 bit, enables autonomous obstacle avoidance.
REQ-011 SHALL have port man_cmd, input, 3 bits, operator command (synchronized upstream).
REQ-012 SHALL have port cm, input, 20 bits, measured distance in cm.
REQ-013 SHALL have port cm_valid, input, 1 bit, one-cycle pulse qualifying cm.
REQ-014 SHALL have port cmd, output, 3 bits, registered command to the drive controller.
REQ-015 SHALL have port override, output, 1 bit, high whenever cmd is not sourced from man_cmd.
REQ-016 SHALL have port fault, output, 1 bit, high while the distance data is stale.
REQ-017 SHALL have port seq_state, output, 3 bits, current FSM state for debug or display.

Function
REQ-018 SHALL use the command encoding 0 zero, 1 acc, 2 dec, 3 left, 4 right, 5 forward, 6 back, 7 stop; commands 1, 2 and 5 are "advancing".
REQ-019 SHALL register cmd, so a change on man_cmd or a state change appears on cmd exactly 1 cycle later.
REQ-020 SHALL implement the states MANUAL=0, HALT=1, BACKUP=2, TURN=3, CHECK=4 and LOCKOUT=5.
REQ-021 SHALL, in MANUAL, drive cmd=man_cmd; when auto_en && cm_valid && cm<=STOP_CM && man_cmd is advancing, it SHALL go to HALT and clear the retry count.
REQ-022 SHALL, in HALT, drive cmd=7 for HALT_TICKS cycles, then go to BACKUP.
REQ-023 SHALL, in BACKUP, drive cmd=6 for BACK_TICKS cycles, then go to TURN.
REQ-024 SHALL, in TURN, drive cmd=4 for TURN_TICKS cycles, then go to CHECK and increment the retry count.
REQ-025 SHALL, in CHECK, drive cmd=7 and wait for the next cm_valid. If cm>CLEAR_CM it goes to MANUAL; otherwise it goes to BACKUP if retry<MAX_RETRY, or to LOCKOUT if not.
REQ-026 SHALL, in LOCKOUT, drive cmd=7 until man_cmd==7 is sampled (operator acknowledgement), then go to MANUAL.
REQ-027 SHALL count dwell with one 32-bit down-counter: it is loaded with TICKS-1 on state entry, and the exit fires on the cycle the counter is 0, so each state lasts exactly TICKS cycles.
REQ-028 SHALL ignore cm_valid in HALT, BACKUP and TURN.
REQ-029 SHALL force the state to MANUAL on the next edge when auto_en is low in any state; this has priority over all other transitions.
REQ-030 SHALL keep a 32-bit stale counter that is cleared on cm_valid and saturates at STALE_TICKS; fault=1 when auto_en && counter==STALE_TICKS.
REQ-031 SHALL, while fault=1 in MANUAL, replace advancing man_cmd values with 7; non-advancing values pass through unchanged.
REQ-032 SHALL, in CHECK with fault=1, go to LOCKOUT.
REQ-033 SHALL drive override=1 in every state except MANUAL, and also in MANUAL while the fault substitution is active.
REQ-034 SHALL use unsigned 20-bit comparisons, and the retry counter SHALL be wide enough to hold MAX_RETRY.

Reset
REQ-035 SHALL, on reset, set state=MANUAL, cmd=0, override=0, fault=0, the timer to 0, retry to 0 and the stale counter to 0.
REQ-036 SHALL, on reset asserted mid-sequence, abort the sequence immediately, with cmd=0 while rst is high.

Structure
REQ-037 SHALL place the command encoding constants and the state encoding in shared package car_pkg, for use by car_control as well.
REQ-038 SHALL implement the dwell down-counter as sub-module seq_timer (ports: load, load_val, zero flag).

Verification (sim parameters: HALT=4, BACK=6, TURN=5, STOP_CM=25, CLEAR_CM=40, MAX_RETRY=2, STALE=20)
REQ-039 SHALL cover: man_cmd=5, auto_en=1, cm_valid with cm=25 -> cmd 7 for 4 cycles, 6 for 6, 4 for 5, then 7; cm_valid with cm=41 -> cmd=5 on the next cycle, override=0.
REQ-040 SHALL cover: the same sequence but with cm=40 in CHECK twice -> a second BACKUP/TURN, then LOCKOUT with cmd=7; man_cmd=7 -> MANUAL.
REQ-041 SHALL cover: man_cmd=6 with cm=10 valid -> no takeover, cmd=6; and man_cmd=5 with cm=26 -> no takeover.
REQ-042 SHALL cover: auto_en dropped during BACKUP -> MANUAL on the next edge, cmd=man_cmd one cycle after that.
REQ-043 SHALL cover: no cm_valid for 20 cycles with man_cmd=5 -> fault=1, cmd=7, override=1; a cm_valid with cm=100 -> fault=0, cmd=5.
REQ-044 SHALL cover: rst pulsed during TURN -> cmd=0 and state=MANUAL immediately, asynchronously.
